// File: rtl/dispense_pkg.sv
// Shared types and constants for the multi-channel servo dispenser.
// Servo codes, FSM state encoding and the ms-to-cycles conversion.
package dispense_pkg;

   localparam logic [1:0] SERVO_STOP   = 2'b00;
   localparam logic [1:0] SERVO_PUSH   = 2'b01;
   localparam logic [1:0] SERVO_REVERT = 2'b10;

   typedef enum logic [1:0] {IDLE, PUSH, REVERT, WAIT} state_t;

   function automatic logic [31:0] ms_to_cyc(input longint unsigned freq, input longint unsigned ms);
      return 32'(freq / 1000 * ms);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set flag at or after rr_ptr, wrapping.
module rr_pick #(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = $clog2(NUM_CH)
)(
   input  logic [NUM_CH-1:0] flags,
   input  logic [IDX_W-1:0]  rr_ptr,
   output logic              valid,
   output logic [IDX_W-1:0]  index
);

   int               jj;
   logic [IDX_W-1:0] j;

   // Scan from the farthest offset down so the nearest hit is assigned last.
   always_comb begin
      valid = |flags;
      index = '0;
      jj    = 0;
      j     = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         jj = int'(rr_ptr) + k;
         if (jj >= NUM_CH) jj = jj - NUM_CH;
         j = IDX_W'(jj);
         if (flags[j]) index = j;
      end
   end

endmodule

// File: rtl/multi_dispense_controller.sv
// Round-robin controller for NUM_CH servo/LED dispensers sharing one power budget:
// one queued order per channel, one servo moving at a time, global abort.
module multi_dispense_controller
   import dispense_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 4,
   parameter int CLK_FREQ  = 50_000_000,
   parameter int PUSH_MS   = 500,
   parameter int REVERT_MS = 500,
   parameter int WAIT_MS   = 500
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [$clog2(NUM_CH)-1:0] req_ch,
   input  logic [CNT_W-1:0]          req_count,
   input  logic                      abort,
   output logic [2*NUM_CH-1:0]       servo_control,
   output logic [NUM_CH-1:0]         led_out,
   output logic [NUM_CH-1:0]         ch_pending,
   output logic                      busy,
   output logic                      done_valid,
   output logic [$clog2(NUM_CH)-1:0] done_ch,
   output logic                      done_aborted
);

   localparam int          CH_W        = $clog2(NUM_CH);
   localparam logic [31:0] PUSH_LAST   = ms_to_cyc(CLK_FREQ, PUSH_MS) - 32'd1;
   localparam logic [31:0] REVERT_LAST = ms_to_cyc(CLK_FREQ, REVERT_MS) - 32'd1;
   localparam logic [31:0] WAIT_LAST   = ms_to_cyc(CLK_FREQ, WAIT_MS) - 32'd1;

   state_t                        state, state_nx;
   logic [31:0]                   timer;
   logic [NUM_CH-1:0][CNT_W-1:0]  pending;
   logic [NUM_CH-1:0]             flags;
   logic [CH_W-1:0]               rr_ptr, act_ch, pick_idx;
   logic [CNT_W-1:0]              act_cnt;
   logic                          pick_vld, aborted, ch_free, accept;
   logic                          sel, dec, done_set, dab_set, last_item;

   rr_pick #(.NUM_CH(NUM_CH), .IDX_W(CH_W)) u_pick (
      .flags  (flags),
      .rr_ptr (rr_ptr),
      .valid  (pick_vld),
      .index  (pick_idx)
   );

   always_comb begin
      flags   = '0;
      ch_free = 1'b1;
      act_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         flags[i] = pending[i] != '0;
         if (req_ch == CH_W'(i)) ch_free = pending[i] == '0;
         if (act_ch == CH_W'(i)) act_cnt = pending[i];
      end
   end

   assign req_ready = !abort && ch_free;
   assign accept    = req_valid && req_ready;
   // Once aborted, the active channel's count is gone (and may even hold a fresh order).
   assign last_item = abort || aborted || (act_cnt <= CNT_W'(1));

   always_comb begin
      state_nx = state;
      sel      = 1'b0;
      dec      = 1'b0;
      done_set = 1'b0;
      dab_set  = 1'b0;
      case (state)
         IDLE: begin
            if (!abort && pick_vld) begin
               state_nx = PUSH;
               sel      = 1'b1;
            end
         end
         PUSH: begin
            if (abort || timer == PUSH_LAST) state_nx = REVERT;
         end
         REVERT: begin
            if (timer == REVERT_LAST) begin
               dec = !aborted;
               if (last_item) begin
                  state_nx = IDLE;
                  done_set = 1'b1;
                  dab_set  = aborted || abort;
               end else begin
                  state_nx = WAIT;
               end
            end
         end
         WAIT: begin
            if (abort) begin
               state_nx = IDLE;
               done_set = 1'b1;
               dab_set  = 1'b1;
            end else if (timer == WAIT_LAST) begin
               state_nx = PUSH;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         timer        <= '0;
         pending      <= '0;
         rr_ptr       <= '0;
         act_ch       <= '0;
         aborted      <= 1'b0;
         done_valid   <= 1'b0;
         done_ch      <= '0;
         done_aborted <= 1'b0;
      end else begin
         state        <= state_nx;
         timer        <= (state_nx != state) ? '0 : timer + 32'd1;
         done_valid   <= done_set;
         done_aborted <= done_set && dab_set;
         if (sel) act_ch <= pick_idx;
         if (done_set) done_ch <= act_ch;
         if (done_set && state == REVERT)
            rr_ptr <= (act_ch == CH_W'(NUM_CH - 1)) ? '0 : act_ch + CH_W'(1);
         if (state_nx == IDLE) aborted <= 1'b0;
         else if (abort)       aborted <= 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            if (abort)
               pending[i] <= '0;
            else if (accept && req_ch == CH_W'(i))
               pending[i] <= req_count;
            else if (dec && act_ch == CH_W'(i))
               pending[i] <= pending[i] - CNT_W'(1);
         end
      end
   end

   assign busy = state != IDLE;

   always_comb begin
      servo_control = '0;
      led_out       = '0;
      ch_pending    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_pending[i] = flags[i] || (busy && act_ch == CH_W'(i));
         if (act_ch == CH_W'(i) && state == PUSH) begin
            servo_control[2*i +: 2] = SERVO_PUSH;
            led_out[i]              = 1'b1;
         end else if (act_ch == CH_W'(i) && state == REVERT) begin
            servo_control[2*i +: 2] = SERVO_REVERT;
            led_out[i]              = 1'b1;
         end
      end
   end

endmodule
